harris_response: RTL and testbench
==================================

# harris_response

Pipelined Harris corner-response stage fed directly by the 6-line image window controller. Each valid 6×6 pixel window yields a corner flag and a signed response value. The stage computes central-difference gradients on the inner 4×4, sums the structure-tensor terms, and evaluates R = det − trace²/16 against a threshold. It has no backpressure: the stage accepts one window per clock, in lock-step with the upstream valid.

## Interface
- IMG_WIDTH, 480, output pixels per line; width of the column counter wrap.
- OUT_LINES, 475, output lines per frame; sets the o_eof position.
- THRESHOLD, 44'sd1000000000, signed; a corner is flagged when R > THRESHOLD.
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_window  in  288  6×6 window; pixel (r,c) = i_window[48*r+8*c +: 8], unsigned; r=0 is the oldest row, c=0 the leftmost column.
- i_window_valid  in  1  window qualifier.
- o_response  out  44  signed R.
- o_corner  out  1  corner flag.
- o_valid  out  1  output qualifier.
- o_eol  out  1  high with the last output of a line.
- o_eof  out  1  high with the last output of a frame.

## Operation
- Gradients at interior positions r,c ∈ 1..4:
  - Ix = p[r][c+1] − p[r][c−1]
  - Iy = p[r+1][c] − p[r−1][c]
  - Each is 9-bit signed.
- Products: Ix², Iy² are 16-bit unsigned; IxIy is 17-bit signed.
- Sums over the 16 positions: Sxx, Syy are 20-bit unsigned; Sxy is 21-bit signed.
- det = Sxx·Syy − Sxy², 42-bit signed.
- trace = Sxx+Syy, 21-bit. trace²>>4 uses a logical shift and is truncated toward zero.
- R = det − (trace²>>4), sign-extended to 44 bits. No saturation is needed, because the widths cover the full range.
- o_corner = (R > THRESHOLD), signed compare.
- Pipeline stages:
  - S1: gradients.
  - S2: products.
  - S3: four row partial sums.
  - S4: totals.
  - S5: det and trace².
  - S6: R and compare.
  - A valid shift register runs alongside the data. Data registers load only when their stage valid is high.
- Position counters (col: 0..IMG_WIDTH−1, row: 0..OUT_LINES−1) advance on each o_valid:
  - o_eol = o_valid & (col == IMG_WIDTH−1). On eol, col wraps to 0 and row increments.
  - o_eof = o_eol & (row == OUT_LINES−1). On eof, row wraps to 0.
- Gaps in i_window_valid, e.g. between lines, produce bubbles. Counters hold during bubbles.

## Timing
- Latency: a window sampled at edge N appears on the outputs after edge N+6.
- Throughput: 1 window per clock.
- Reset: all outputs, the valid pipeline, col and row go to 0 immediately on i_rst assertion. Data registers also go to 0.
- Reset mid-operation discards in-flight windows. The first output after release is for the first window sampled after release, with col=0, row=0.
- Back-to-back lines with no gap: the eol and wrap happen on the same edge the next line's first output is counted. Counter behaviour is unchanged.
- o_eol and o_eof are never high while o_valid is low.

## Configuration
- HARRIS_BORDER_MASK_EN:
  - Defined: o_corner is forced to 0 when col < 2 or col > IMG_WIDTH−3, because those windows straddle line edges. o_response is unaffected.
  - Undefined: o_corner is never masked.

## Test plan
- Flat window, all pixels 100, one valid -> 6 cycles later: o_valid=1, o_response=0, o_corner=0.
- Vertical edge, columns 0–2 = 0 and 3–5 = 255 -> Sxx=520200, Syy=Sxy=0, o_response=−16913002500, o_corner=0.
- Corner pattern, pixel = 255 where r≥3 & c≥3, else 0 -> Sxx=Syy=260100, Sxy=65025, o_response=46510756875, o_corner=1.
- Stream of 480×475 windows with a 10-cycle gap between lines -> 475 o_eol pulses and exactly one o_eof, coincident with the last o_eol. Without HARRIS_BORDER_MASK_EN, the corner pattern at col 0 flags; with the macro defined, it does not.
- Assert i_rst for 1 cycle with 4 windows in flight -> o_valid stays 0 until a new window is sampled plus 6 cycles. The next output has col=0 and row=0.

Source files
------------

// File: rtl/harris_response_if.sv
// Window-in / response-out bundle for the Harris corner-response stage.
// master drives windows and observes results; slave is the stage itself.
interface harris_response_if;
    logic [287:0]        i_window;
    logic                i_window_valid;
    logic signed [43:0]  o_response;
    logic                o_corner;
    logic                o_valid;
    logic                o_eol;
    logic                o_eof;

    modport master (
        output i_window, i_window_valid,
        input  o_response, o_corner, o_valid, o_eol, o_eof
    );

    modport slave (
        input  i_window, i_window_valid,
        output o_response, o_corner, o_valid, o_eol, o_eof
    );
endinterface

// File: rtl/harris_response.sv
// Harris corner response R = det - trace^2/16 on a 6x6 window, one window per clock.
// Latency: window sampled at edge N appears after edge N+6. No backpressure.
// HARRIS_BORDER_MASK_EN: when defined, o_corner is suppressed for windows near line edges.
module harris_response #(
    parameter int                IMG_WIDTH = 480,
    parameter int                OUT_LINES = 475,
    parameter logic signed [43:0] THRESHOLD = 44'sd1000000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    harris_response_if.slave   bus
);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (OUT_LINES > 1) ? $clog2(OUT_LINES) : 1;

    logic [5:0]          vld_q, vld_d;
    logic signed [8:0]   ix_q [4][4], ix_d [4][4];
    logic signed [8:0]   iy_q [4][4], iy_d [4][4];
    logic [15:0]         xx_q [4][4], xx_d [4][4];
    logic [15:0]         yy_q [4][4], yy_d [4][4];
    logic signed [16:0]  xy_q [4][4], xy_d [4][4];
    logic [17:0]         rxx_q [4], rxx_d [4];
    logic [17:0]         ryy_q [4], ryy_d [4];
    logic signed [18:0]  rxy_q [4], rxy_d [4];
    logic [19:0]         sxx_q, sxx_d, syy_q, syy_d;
    logic signed [20:0]  sxy_q, sxy_d;
    logic signed [41:0]  det_q, det_d;
    logic [41:0]         tr2_q, tr2_d, tr_w;
    logic signed [43:0]  r_q, r_d;
    logic                cmp_q, cmp_d;
    logic signed [43:0]  resp_q, resp_d;
    logic                corner_q, corner_d, valid_q, valid_d;
    logic                eol_q, eol_d, eof_q, eof_d, edge_w;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;

    always_comb begin
        vld_d    = {vld_q[4:0], bus.i_window_valid};
        ix_d     = ix_q;   iy_d  = iy_q;
        xx_d     = xx_q;   yy_d  = yy_q;   xy_d  = xy_q;
        rxx_d    = rxx_q;  ryy_d = ryy_q;  rxy_d = rxy_q;
        sxx_d    = sxx_q;  syy_d = syy_q;  sxy_d = sxy_q;
        det_d    = det_q;  tr2_d = tr2_q;  tr_w  = '0;
        r_d      = r_q;    cmp_d = cmp_q;
        resp_d   = resp_q; corner_d = corner_q;
        valid_d  = 1'b0;   eol_d = 1'b0;   eof_d = 1'b0;
        col_d    = col_q;  row_d = row_q;

        // Array index (r,c) maps to window interior position (r+1,c+1).
        if (bus.i_window_valid) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    ix_d[r][c] = $signed({1'b0, bus.i_window[48*(r+1)+8*(c+2) +: 8]})
                               - $signed({1'b0, bus.i_window[48*(r+1)+8*c +: 8]});
                    iy_d[r][c] = $signed({1'b0, bus.i_window[48*(r+2)+8*(c+1) +: 8]})
                               - $signed({1'b0, bus.i_window[48*r+8*(c+1) +: 8]});
                end
            end
        end

        // Products fit their result widths exactly, so modular multiplies are exact.
        if (vld_q[0]) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    xx_d[r][c] = 16'(ix_q[r][c]) * 16'(ix_q[r][c]);
                    yy_d[r][c] = 16'(iy_q[r][c]) * 16'(iy_q[r][c]);
                    xy_d[r][c] = 17'(ix_q[r][c]) * 17'(iy_q[r][c]);
                end
            end
        end

        if (vld_q[1]) begin
            for (int r = 0; r < 4; r++) begin
                rxx_d[r] = 18'(xx_q[r][0]) + 18'(xx_q[r][1]) + 18'(xx_q[r][2]) + 18'(xx_q[r][3]);
                ryy_d[r] = 18'(yy_q[r][0]) + 18'(yy_q[r][1]) + 18'(yy_q[r][2]) + 18'(yy_q[r][3]);
                rxy_d[r] = 19'(xy_q[r][0]) + 19'(xy_q[r][1]) + 19'(xy_q[r][2]) + 19'(xy_q[r][3]);
            end
        end

        if (vld_q[2]) begin
            sxx_d = 20'(rxx_q[0]) + 20'(rxx_q[1]) + 20'(rxx_q[2]) + 20'(rxx_q[3]);
            syy_d = 20'(ryy_q[0]) + 20'(ryy_q[1]) + 20'(ryy_q[2]) + 20'(ryy_q[3]);
            sxy_d = 21'(rxy_q[0]) + 21'(rxy_q[1]) + 21'(rxy_q[2]) + 21'(rxy_q[3]);
        end

        if (vld_q[3]) begin
            tr_w  = 42'(sxx_q) + 42'(syy_q);
            det_d = 42'(sxx_q) * 42'(syy_q) - 42'(sxy_q) * 42'(sxy_q);
            tr2_d = tr_w * tr_w;
        end

        if (vld_q[4]) begin
            r_d   = 44'(det_q) - 44'(tr2_q >> 4);
            cmp_d = (r_d > THRESHOLD);
        end

`ifdef HARRIS_BORDER_MASK_EN
        edge_w = (col_q < CW'(2)) || (col_q > CW'(IMG_WIDTH - 3));
`else
        edge_w = 1'b0;
`endif

        // col_q/row_q hold the position of the next output to be emitted.
        if (vld_q[5]) begin
            valid_d  = 1'b1;
            resp_d   = r_q;
            corner_d = cmp_q & ~edge_w;
            eol_d    = (col_q == CW'(IMG_WIDTH - 1));
            eof_d    = eol_d && (row_q == RW'(OUT_LINES - 1));
            col_d    = eol_d ? '0 : col_q + CW'(1);
            row_d    = eof_d ? '0 : (eol_d ? row_q + RW'(1) : row_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q    <= '0;
            ix_q     <= '{default: '0};  iy_q <= '{default: '0};
            xx_q     <= '{default: '0};  yy_q <= '{default: '0};  xy_q <= '{default: '0};
            rxx_q    <= '{default: '0};  ryy_q <= '{default: '0}; rxy_q <= '{default: '0};
            sxx_q    <= '0;  syy_q <= '0;  sxy_q <= '0;
            det_q    <= '0;  tr2_q <= '0;  r_q <= '0;  cmp_q <= 1'b0;
            resp_q   <= '0;  corner_q <= 1'b0;  valid_q <= 1'b0;
            eol_q    <= 1'b0;  eof_q <= 1'b0;  col_q <= '0;  row_q <= '0;
        end else begin
            vld_q    <= vld_d;
            ix_q     <= ix_d;   iy_q  <= iy_d;
            xx_q     <= xx_d;   yy_q  <= yy_d;   xy_q  <= xy_d;
            rxx_q    <= rxx_d;  ryy_q <= ryy_d;  rxy_q <= rxy_d;
            sxx_q    <= sxx_d;  syy_q <= syy_d;  sxy_q <= sxy_d;
            det_q    <= det_d;  tr2_q <= tr2_d;  r_q <= r_d;  cmp_q <= cmp_d;
            resp_q   <= resp_d; corner_q <= corner_d;  valid_q <= valid_d;
            eol_q    <= eol_d;  eof_q <= eof_d;  col_q <= col_d;  row_q <= row_d;
        end
    end

    assign bus.o_response = resp_q;
    assign bus.o_corner   = corner_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_eol      = eol_q;
    assign bus.o_eof      = eof_q;
endmodule

// File: tb/tb_harris_response.sv
// Directed and random windows through harris_response, checked against a queue of expected outputs.
module tb_harris_response;
    localparam int W = 8;
    localparam int L = 4;
    localparam logic signed [43:0] THR = 44'sd1000000000;

    logic i_clk = 1'b0;
    logic i_rst;
    harris_response_if bus();

    harris_response #(.IMG_WIDTH(W), .OUT_LINES(L), .THRESHOLD(THR)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic signed [43:0] resp;
        logic               corner;
        logic               eol;
        logic               eof;
        int                 cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int checks = 0, failures = 0, cyc = 0;
    int tcol = 0, trow = 0, eol_cnt = 0, eof_cnt = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [287:0] pat(input int kind);
        logic [287:0] w;
        w = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                case (kind)
                    0:       w[48*r+8*c +: 8] = 8'd100;
                    1:       w[48*r+8*c +: 8] = (c >= 3) ? 8'd255 : 8'd0;
                    default: w[48*r+8*c +: 8] = (r >= 3 && c >= 3) ? 8'd255 : 8'd0;
                endcase
        return w;
    endfunction

    function automatic logic [287:0] rnd_win();
        logic [287:0] w;
        for (int i = 0; i < 36; i++) w[8*i +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    function automatic longint model_r(input logic [287:0] w);
        longint sxx = 0, syy = 0, sxy = 0, ix, iy, det, tr;
        for (int r = 1; r <= 4; r++)
            for (int c = 1; c <= 4; c++) begin
                ix = longint'(w[48*r+8*(c+1) +: 8]) - longint'(w[48*r+8*(c-1) +: 8]);
                iy = longint'(w[48*(r+1)+8*c +: 8]) - longint'(w[48*(r-1)+8*c +: 8]);
                sxx += ix * ix;
                syy += iy * iy;
                sxy += ix * iy;
            end
        det = sxx * syy - sxy * sxy;
        tr  = sxx + syy;
        return det - (tr * tr) / 16;
    endfunction

    function automatic bit masked(input int col);
`ifdef HARRIS_BORDER_MASK_EN
        return (col < 2) || (col > W - 3);
`else
        return (col < 0);
`endif
    endfunction

    task automatic push(input logic signed [43:0] r);
        exp_t e;
        e.resp   = r;
        e.corner = (r > THR) && !masked(tcol);
        e.eol    = (tcol == W - 1);
        e.eof    = e.eol && (trow == L - 1);
        e.cyc    = cyc + 7;
        sbq.push_back(e);
        if (e.eol) begin
            tcol = 0;
            trow = e.eof ? 0 : trow + 1;
        end else begin
            tcol++;
        end
    endtask

    task automatic send_k(input logic [287:0] w, input logic signed [43:0] r);
        @(posedge i_clk); #1;
        bus.i_window       = w;
        bus.i_window_valid = 1'b1;
        push(r);
    endtask

    task automatic send(input logic [287:0] w);
        send_k(w, 44'(model_r(w)));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
            bus.i_window_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (sbq.size() == 0) break;
            @(posedge i_clk);
        end
        checks++;
        assert (sbq.size() == 0) else begin
            failures++;
            $error("FAIL %s_drain pending=%0d required=0", tag, sbq.size());
        end
    endtask

    always @(negedge i_clk) begin
        if (bus.o_valid === 1'b1) begin
            checks++;
            assert (sbq.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_valid observed=1 expected=0 cyc=%0d", cyc);
            end
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                checks++;
                assert (bus.o_response === mon_e.resp) else begin
                    failures++;
                    $error("FAIL response observed=%0d expected=%0d", bus.o_response, mon_e.resp);
                end
                checks++;
                assert (bus.o_corner === mon_e.corner) else begin
                    failures++;
                    $error("FAIL corner observed=%0b expected=%0b", bus.o_corner, mon_e.corner);
                end
                checks++;
                assert (bus.o_eol === mon_e.eol) else begin
                    failures++;
                    $error("FAIL eol observed=%0b expected=%0b", bus.o_eol, mon_e.eol);
                end
                checks++;
                assert (bus.o_eof === mon_e.eof) else begin
                    failures++;
                    $error("FAIL eof observed=%0b expected=%0b", bus.o_eof, mon_e.eof);
                end
                checks++;
                assert (cyc === mon_e.cyc) else begin
                    failures++;
                    $error("FAIL latency observed_cyc=%0d expected_cyc=%0d", cyc, mon_e.cyc);
                end
            end
            if (bus.o_eol === 1'b1) eol_cnt++;
            if (bus.o_eof === 1'b1) eof_cnt++;
        end else begin
            checks++;
            assert ({bus.o_eol, bus.o_eof} === 2'b00) else begin
                failures++;
                $error("FAIL flags_without_valid observed=%b expected=00", {bus.o_eol, bus.o_eof});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_window       = '0;
        bus.i_window_valid = 1'b0;
        i_rst              = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        assert ({bus.o_valid, bus.o_corner, bus.o_eol, bus.o_eof} === 4'b0000) else begin
            failures++;
            $error("FAIL reset_flags observed=%b expected=0000",
                   {bus.o_valid, bus.o_corner, bus.o_eol, bus.o_eof});
        end
        checks++;
        assert (bus.o_response === 44'sd0) else begin
            failures++;
            $error("FAIL reset_response observed=%0d expected=0", bus.o_response);
        end
        i_rst = 1'b0;
        idle(2);

        // Frame 1, line 0: known patterns, random noise, corners at both edges.
        send_k(pat(0), 44'sd0);
        send_k(pat(1), -44'sd16913002500);
        send_k(pat(2), 44'sd46510756875);
        idle(1);
        send(rnd_win());
        send(rnd_win());
        send(pat(2));
        idle(2);
        send(rnd_win());
        send(pat(2));
        idle(10);
        // Line 1: all corners, exercises border masking at cols 0,1,W-2,W-1.
        for (int i = 0; i < W; i++) send_k(pat(2), 44'sd46510756875);
        idle(10);
        for (int i = 0; i < W; i++) send(((i % 3) == 0) ? pat(1) : rnd_win());
        // Line 3 follows line 2 with no gap.
        for (int i = 0; i < W; i++) send((i == 4) ? pat(0) : rnd_win());
        idle(1);
        drain("frame1");
        checks++;
        assert (eol_cnt === L) else begin
            failures++;
            $error("FAIL eol_count observed=%0d expected=%0d", eol_cnt, L);
        end
        checks++;
        assert (eof_cnt === 1) else begin
            failures++;
            $error("FAIL eof_count observed=%0d expected=1", eof_cnt);
        end

        // Start of frame 2, then reset with four windows in flight.
        for (int i = 0; i < 3; i++) send(rnd_win());
        idle(1);
        drain("frame2_head");
        for (int i = 0; i < 4; i++) send(pat(2));
        @(posedge i_clk); #1;
        bus.i_window_valid = 1'b0;
        i_rst = 1'b1;
        sbq.delete();
        tcol = 0;
        trow = 0;
        eol_cnt = 0;
        eof_cnt = 0;
        #1;
        checks++;
        assert (bus.o_valid === 1'b0) else begin
            failures++;
            $error("FAIL reset_midstream_valid observed=%b expected=0", bus.o_valid);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        idle(10);

        // Full frame after reset, back-to-back lines; positions must restart at 0,0.
        for (int i = 0; i < W * L; i++) send(((i % 5) == 0) ? pat(2) : rnd_win());
        idle(1);
        drain("post_reset");
        checks++;
        assert (eol_cnt === L) else begin
            failures++;
            $error("FAIL post_reset_eol_count observed=%0d expected=%0d", eol_cnt, L);
        end
        checks++;
        assert (eof_cnt === 1) else begin
            failures++;
            $error("FAIL post_reset_eof_count observed=%0d expected=1", eof_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
